fixed_mul_seq: RTL and testbench

FIXED_MUL_SEQ -- requirements
Module: fixed_mul_seq

---
 rtl/fixed_mul_seq.sv | 114 +++++++++++
 tb/tb_fixed_mul_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_mul_seq.sv
// Sequential signed fixed-point multiplier (shift-add, one multiplier bit per cycle, WIDTH+1 cycle latency).
// Optional macro FIXED_MUL_SAT_EN: saturate on overflow instead of wrapping.
module fixed_mul_seq #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sq,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int AW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

   state_t           state;
   logic             sign;
   logic [AW-1:0]    acc;
   logic [AW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] bsel;
   logic [WIDTH-1:0] amag;
   logic [WIDTH-1:0] bmag;
   logic [AW-1:0]    mag;
   logic             mag_ovf;
   logic [WIDTH-1:0] mag_lo;
   logic [WIDTH-1:0] signed_lo;
   logic [WIDTH-1:0] sat_val;

   // The most-negative operand negates to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
   always_comb begin
      bsel      = sq ? a : b;
      amag      = a[WIDTH-1]    ? (~a + WIDTH'(1))    : a;
      bmag      = bsel[WIDTH-1] ? (~bsel + WIDTH'(1)) : bsel;
      mag       = acc >> FRAC;
      mag_ovf   = |mag[AW-1:WIDTH-1];
      mag_lo    = mag[WIDTH-1:0];
      signed_lo = sign ? (~mag_lo + WIDTH'(1)) : mag_lo;
      sat_val   = sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         sign      <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign     <= a[WIDTH-1] ^ bsel[WIDTH-1];
                  mcand    <= {{WIDTH{1'b0}}, amag};
                  mplier   <= bmag;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= MUL;
               end
            end
            MUL: begin
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1))
                  state <= FIN;
            end
            FIN: begin
               ovf <= mag_ovf;
`ifdef FIXED_MUL_SAT_EN
               result <= mag_ovf ? sat_val : signed_lo;
`else
               result <= signed_lo;
`endif
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef FIXED_MUL_SAT_EN
   logic unused_sat;
   assign unused_sat = ^sat_val;
`endif

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Randomized self-checking bench for fixed_mul_seq (WIDTH=32, FRAC=16) against an arithmetic reference model.
module tb_fixed_mul_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sq;
   logic [31:0] result;
   logic        ovf;
   logic        out_valid;
   logic        out_ready;

   int n_cmp = 0;
   int n_err = 0;

   fixed_mul_seq #(.WIDTH(32), .FRAC(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sq(sq), .result(result), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: true signed product, magnitude truncated by FRAC bits, then overflow/sign rules.
   function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic msq, output logic mov);
      longint pa, pb, prod;
      longint unsigned mag;
      logic sgn;
      logic [31:0] lo;
      pa   = longint'($signed(ma));
      pb   = msq ? pa : longint'($signed(mb));
      prod = pa * pb;
      sgn  = (pa < 0) ^ (pb < 0);
      mag  = (prod < 0) ? longint'(-prod) : prod;
      mag  = mag >> 16;
      mov  = (mag >= 64'h8000_0000);
      lo   = 32'(mag);
`ifdef FIXED_MUL_SAT_EN
      if (mov) return sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return sgn ? (32'd0 - lo) : lo;
   endfunction

   // Drives one operation from IDLE (caller is 1 time unit after an edge) and consumes its result.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tsq,
                         output logic [31:0] r, output logic o, output int lat);
      a = ta; b = tb_v; sq = tsq; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      a = $urandom; b = $urandom; sq = $urandom_range(0, 1);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result; o = ovf;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000; sq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp += 4;
      if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (result !== 32'd0)   begin n_err++; $display("FAIL reset_result got=%h want=0", result); end
      if (ovf !== 1'b0)       begin n_err++; $display("FAIL reset_ovf got=%b want=0", ovf); end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_vectors();
      logic [31:0] va [7] = '{32'h0001_8000, 32'hFFFE_8000, 32'h0000_0001, 32'hFFFC_0000,
                              32'h0100_0000, 32'h0100_0000, 32'h8000_0000};
      logic [31:0] vb [7] = '{32'h0002_0000, 32'h0002_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                              32'h0100_0000, 32'hFF00_0000, 32'h0001_0000};
      logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] r, er;
      logic o, eo;
      int lat;
      for (int i = 0; i < 7; i++) begin
         er = model(va[i], vb[i], vs[i], eo);
         run_op(va[i], vb[i], vs[i], r, o, lat);
         n_cmp += 4;
         if (r !== er)        begin n_err++; $display("FAIL vec%0d_result got=%h want=%h", i, r, er); end
         if (o !== eo)        begin n_err++; $display("FAIL vec%0d_ovf got=%b want=%b", i, o, eo); end
         if (lat != 33)       begin n_err++; $display("FAIL vec%0d_latency got=%0d want=33", i, lat); end
         if (in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_idle got=%b want=1", i, in_ready); end
         if (i == 0) begin
            n_cmp++;
            if (r !== 32'h0003_0000) begin n_err++; $display("FAIL vec0_const got=%h want=00030000", r); end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ta, tb_v, r, er;
      logic tsq, o, eo;
      int lat;
      for (int i = 0; i < 40; i++) begin
         ta   = $signed($urandom) >>> $urandom_range(0, 24);
         tb_v = $signed($urandom) >>> $urandom_range(0, 24);
         tsq  = ($urandom_range(0, 3) == 0);
         er   = model(ta, tb_v, tsq, eo);
         run_op(ta, tb_v, tsq, r, o, lat);
         n_cmp += 3;
         if (r !== er)  begin n_err++; $display("FAIL rnd%0d_result a=%h b=%h sq=%b got=%h want=%h", i, ta, tb_v, tsq, r, er); end
         if (o !== eo)  begin n_err++; $display("FAIL rnd%0d_ovf got=%b want=%b", i, o, eo); end
         if (lat != 33) begin n_err++; $display("FAIL rnd%0d_latency got=%0d want=33", i, lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2, e1, e2;
      logic eo;
      int lat;
      a1 = 32'hFFFE_8000; b1 = 32'h0003_4000; a2 = 32'h0000_C000; b2 = 32'hFFF9_0000;
      e1 = model(a1, b1, 1'b0, eo);
      e2 = model(a2, b2, 1'b0, eo);
      a = a1; b = b1; sq = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      n_cmp++;
      if (lat != 33) begin n_err++; $display("FAIL bp_latency got=%0d want=33", lat); end
      for (int i = 0; i < 5; i++) begin
         a = $urandom; b = $urandom; in_valid = 1'b1;
         @(posedge clk); #1;
         n_cmp += 3;
         if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d_valid got=%b want=1", i, out_valid); end
         if (result !== e1)      begin n_err++; $display("FAIL bp_hold%0d_result got=%h want=%h", i, result, e1); end
         if (in_ready !== 1'b0)  begin n_err++; $display("FAIL bp_hold%0d_in_ready got=%b want=0", i, in_ready); end
      end
      a = a2; b = b2; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp += 2;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_release_valid got=%b want=0", out_valid); end
      if (in_ready !== 1'b1)  begin n_err++; $display("FAIL b2b_release_in_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept got=%b want=0", in_ready); end
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      n_cmp += 2;
      if (lat != 33)    begin n_err++; $display("FAIL b2b_latency got=%0d want=33", lat); end
      if (result !== e2) begin n_err++; $display("FAIL b2b_result got=%h want=%h", result, e2); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [31:0] r, er;
      logic o, eo;
      int lat;
      a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; sq = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp += 4;
      if (in_ready !== 1'b1)  begin n_err++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
      if (result !== 32'd0)   begin n_err++; $display("FAIL midrst_result got=%h want=0", result); end
      if (ovf !== 1'b0)       begin n_err++; $display("FAIL midrst_ovf got=%b want=0", ovf); end
      er = model(32'h0002_8000, 32'hFFFF_4000, 1'b0, eo);
      run_op(32'h0002_8000, 32'hFFFF_4000, 1'b0, r, o, lat);
      n_cmp += 3;
      if (r !== er)  begin n_err++; $display("FAIL postrst_result got=%h want=%h", r, er); end
      if (o !== eo)  begin n_err++; $display("FAIL postrst_ovf got=%b want=%b", o, eo); end
      if (lat != 33) begin n_err++; $display("FAIL postrst_latency got=%0d want=33", lat); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sq = 1'b0;
      test_reset();
      test_vectors();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
